collision_ctrl: RTL and testbench

- Downstream consumer of the obstacle and player bounding boxes.
- On every animation strobe it tests the player box against the obstacle box and counts obstacles cleared.
- Runs the game state machine: idle, run, hit, over.
- Drives the obstacle's animate enable and a one-cycle obstacle reset, and supplies score and game-over status to the display/HUD logic.

---
 rtl/collision_ctrl.sv | 130 +++++++++++++
 tb/tb_collision_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_ctrl.sv
// Player/obstacle collision check, score counter and game FSM (IDLE/RUN/HIT/OVER).
// Optional macro HIT_DEBOUNCE_EN: require DEBOUNCE consecutive overlapping strobes to register a hit.
module collision_ctrl #(
  parameter int HIT_FRAMES = 30,
  parameter int SCORE_W    = 14,
  parameter int DEBOUNCE   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_start,
  input  logic [11:0]        i_p_x1,
  input  logic [11:0]        i_p_x2,
  input  logic [11:0]        i_p_y1,
  input  logic [11:0]        i_p_y2,
  input  logic [11:0]        i_o_x1,
  input  logic [11:0]        i_o_x2,
  input  logic [11:0]        i_o_y1,
  input  logic [11:0]        i_o_y2,
  output logic               o_animate,
  output logic               o_obs_rst,
  output logic               o_hit,
  output logic               o_flash,
  output logic               o_game_over,
  output logic [SCORE_W-1:0] o_score
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT, S_OVER} state_t;

  state_t       r_state;
  logic [7:0]   r_hit_cnt;
  logic [11:0]  r_prev_x1;
  logic         r_prev_valid;

  logic               w_overlap;
  logic               w_wrap;
  logic               w_enter_hit;
  logic               w_score_ok;
  logic [7:0]         w_hit_inc;
  logic [SCORE_W-1:0] w_score_max;

  // Strict overlap: boxes that only share an edge do not collide.
  assign w_overlap   = (i_p_x1 < i_o_x2) && (i_o_x1 < i_p_x2) &&
                       (i_p_y1 < i_o_y2) && (i_o_y1 < i_p_y2);
  assign w_wrap      = r_prev_valid && (i_o_x1 > r_prev_x1);
  assign w_hit_inc   = r_hit_cnt + 8'd1;
  assign w_score_max = '1;

`ifdef HIT_DEBOUNCE_EN
  logic [2:0] r_run_cnt;
  logic [3:0] w_rc_next;
  assign w_rc_next   = {1'b0, r_run_cnt} + 4'd1;
  assign w_enter_hit = w_overlap && (w_rc_next >= 4'(DEBOUNCE));
  assign w_score_ok  = (r_run_cnt == 3'd0);
`else
  assign w_enter_hit = w_overlap;
  assign w_score_ok  = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_hit_cnt    <= '0;
      r_prev_x1    <= '0;
      r_prev_valid <= 1'b0;
      o_animate    <= 1'b0;
      o_obs_rst    <= 1'b0;
      o_hit        <= 1'b0;
      o_flash      <= 1'b0;
      o_game_over  <= 1'b0;
      o_score      <= '0;
`ifdef HIT_DEBOUNCE_EN
      r_run_cnt    <= '0;
`endif
    end else begin
      o_obs_rst <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (i_start) begin
            r_state      <= S_RUN;
            o_obs_rst    <= 1'b1;
            o_animate    <= 1'b1;
            o_game_over  <= 1'b0;
            o_score      <= '0;
            r_prev_valid <= 1'b0;
`ifdef HIT_DEBOUNCE_EN
            r_run_cnt    <= '0;
`endif
          end
        end
        S_RUN: begin
          if (i_ani_stb) begin
            r_prev_x1    <= i_o_x1;
            r_prev_valid <= 1'b1;
`ifdef HIT_DEBOUNCE_EN
            r_run_cnt    <= w_overlap ? w_rc_next[2:0] : 3'd0;
`endif
            if (w_enter_hit) begin
              r_state   <= S_HIT;
              r_hit_cnt <= '0;
              o_animate <= 1'b0;
              o_hit     <= 1'b1;
              o_flash   <= 1'b0;
`ifdef HIT_DEBOUNCE_EN
              r_run_cnt <= '0;
`endif
            end else if (!w_overlap && w_wrap && w_score_ok && (o_score != w_score_max)) begin
              o_score <= o_score + 1'b1;
            end
          end
        end
        S_HIT: begin
          if (i_ani_stb) begin
            if (r_hit_cnt == 8'(HIT_FRAMES - 1)) begin
              r_state     <= S_OVER;
              o_hit       <= 1'b0;
              o_flash     <= 1'b0;
              o_game_over <= 1'b1;
            end else begin
              r_hit_cnt <= w_hit_inc;
              o_flash   <= w_hit_inc[2];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_ctrl.sv
// Scoreboard bench for collision_ctrl: expected output vectors are queued with each stimulus and checked after the edge.
module tb_collision_ctrl;

  localparam int SW = 14;
`ifdef HIT_DEBOUNCE_EN
  localparam int DB = 2;
`else
  localparam int DB = 1;
`endif

  logic i_clk = 1'b0, i_rst = 1'b0, i_ani_stb = 1'b0, i_start = 1'b0;
  logic [11:0] i_p_x1, i_p_x2, i_p_y1, i_p_y2, i_o_x1, i_o_x2, i_o_y1, i_o_y2;
  logic o_animate, o_obs_rst, o_hit, o_flash, o_game_over;
  logic [SW-1:0] o_score;

  typedef logic [SW+4:0] vec_t;
  vec_t  q[$];
  string nq[$];
  vec_t  e;
  string n;
  int    nerr = 0, nchk = 0;

  collision_ctrl #(.HIT_FRAMES(30), .SCORE_W(SW), .DEBOUNCE(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_start(i_start),
    .i_p_x1(i_p_x1), .i_p_x2(i_p_x2), .i_p_y1(i_p_y1), .i_p_y2(i_p_y2),
    .i_o_x1(i_o_x1), .i_o_x2(i_o_x2), .i_o_y1(i_o_y1), .i_o_y2(i_o_y2),
    .o_animate(o_animate), .o_obs_rst(o_obs_rst), .o_hit(o_hit), .o_flash(o_flash),
    .o_game_over(o_game_over), .o_score(o_score)
  );

  always #5 i_clk = ~i_clk;

  function automatic vec_t outs();
    return {o_animate, o_obs_rst, o_hit, o_flash, o_game_over, o_score};
  endfunction

  function automatic vec_t mk(input logic a, r, h, f, g, input int s);
    return {a, r, h, f, g, SW'(s)};
  endfunction

  task automatic set_box(input int px1, px2, ox1, ox2);
    i_p_x1 = 12'(px1); i_p_x2 = 12'(px2); i_p_y1 = 12'd200; i_p_y2 = 12'd220;
    i_o_x1 = 12'(ox1); i_o_x2 = 12'(ox2); i_o_y1 = 12'd210; i_o_y2 = 12'd240;
  endtask

  task automatic step(input logic stb, input logic st);
    i_ani_stb = stb; i_start = st;
    @(posedge i_clk); #1;
    i_ani_stb = 1'b0; i_start = 1'b0;
  endtask

  task automatic test_reset();
    set_box(80, 100, 90, 110);
    i_rst = 1'b1; #1;
    q.push_back(mk(0,0,0,0,0,0)); nq.push_back("reset_state");
    e = q.pop_front(); n = nq.pop_front(); nchk++;
    if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    @(posedge i_clk); #1; i_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      q.push_back(mk(0,0,0,0,0,0)); nq.push_back("idle_overlap_stb");
      step(1'b1, 1'b0);
      e = q.pop_front(); n = nq.pop_front(); nchk++;
      if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    end
  endtask

  task automatic test_start();
    set_box(80, 100, 600, 620);
    q.push_back(mk(1,1,0,0,0,0)); nq.push_back("start_pulse");
    q.push_back(mk(1,0,0,0,0,0)); nq.push_back("start_after");
    for (int k = 0; k < 2; k++) begin
      step(1'b0, k == 0);
      e = q.pop_front(); n = nq.pop_front(); nchk++;
      if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    end
  endtask

  task automatic test_scoring();
    int xs[13] = '{600, 599, 0, 620, 619, 0, 620, 0, 620, 0, 620, 0, 620};
    int ss[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    for (int k = 0; k < 13; k++) begin
      set_box(80, 100, xs[k], xs[k] + 20);
      q.push_back(mk(1,0,0,0,0,ss[k])); nq.push_back($sformatf("score_%0d", k));
      step(1'b1, 1'b0);
      e = q.pop_front(); n = nq.pop_front(); nchk++;
      if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
      if (k == 4) begin
        set_box(80, 100, 90, 110);
        q.push_back(mk(1,0,0,0,0,1)); nq.push_back("no_stb_overlap");
        step(1'b0, 1'b1);
        e = q.pop_front(); n = nq.pop_front(); nchk++;
        if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
      end else step(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    #2 i_rst = 1'b1; #1;
    q.push_back(mk(0,0,0,0,0,0)); nq.push_back("async_rst_mid_run");
    e = q.pop_front(); n = nq.pop_front(); nchk++;
    if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    @(posedge i_clk); #1; i_rst = 1'b0;
    set_box(80, 100, 90, 110);
    q.push_back(mk(0,0,0,0,0,0)); nq.push_back("idle_after_rst");
    step(1'b1, 1'b0);
    e = q.pop_front(); n = nq.pop_front(); nchk++;
    if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
  endtask

  task automatic test_touch();
    step(1'b0, 1'b1);
    set_box(80, 100, 100, 120);
    q.push_back(mk(1,0,0,0,0,0)); nq.push_back("touch_no_hit");
    step(1'b1, 1'b0);
    e = q.pop_front(); n = nq.pop_front(); nchk++;
    if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    set_box(80, 100, 99, 119);
    for (int k = 1; k <= DB; k++) begin
      q.push_back(k < DB ? mk(1,0,0,0,0,0) : mk(0,0,1,0,0,0)); nq.push_back("overlap_hit");
      step(1'b1, 1'b0);
      e = q.pop_front(); n = nq.pop_front(); nchk++;
      if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    end
  endtask

  task automatic test_hit_over();
    for (int k = 1; k <= 30; k++) begin
      q.push_back(k < 30 ? mk(0,0,1,1'((k >> 2) & 1),0,0) : mk(0,0,0,0,1,0));
      nq.push_back($sformatf("hit_strobe_%0d", k));
      step(1'b1, (k % 5) == 0);
      e = q.pop_front(); n = nq.pop_front(); nchk++;
      if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
      step(1'b0, (k % 7) == 0);
    end
    q.push_back(mk(0,0,0,0,1,0)); nq.push_back("over_hold");
    step(1'b1, 1'b0);
    e = q.pop_front(); n = nq.pop_front(); nchk++;
    if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
  endtask

  task automatic test_restart();
    q.push_back(mk(1,1,0,0,0,0)); nq.push_back("restart_pulse");
    q.push_back(mk(1,0,0,0,0,0)); nq.push_back("restart_after");
    for (int k = 0; k < 2; k++) begin
      step(1'b0, k == 0);
      e = q.pop_front(); n = nq.pop_front(); nchk++;
      if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    end
  endtask

  task automatic test_simultaneous();
    set_box(80, 100, 0, 20);
    q.push_back(mk(1,0,0,0,0,0)); nq.push_back("simul_first");
    step(1'b1, 1'b0);
    e = q.pop_front(); n = nq.pop_front(); nchk++;
    if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    set_box(80, 100, 5, 25);
    q.push_back(mk(1,0,0,0,0,1)); nq.push_back("simul_wrap5");
    step(1'b1, 1'b0);
    e = q.pop_front(); n = nq.pop_front(); nchk++;
    if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    set_box(610, 640, 620, 640);
    for (int k = 1; k <= DB; k++) begin
      q.push_back(k < DB ? mk(1,0,0,0,0,1) : mk(0,0,1,0,0,1)); nq.push_back("simul_hit_wins");
      step(1'b1, 1'b0);
      e = q.pop_front(); n = nq.pop_front(); nchk++;
      if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    end
  endtask

`ifdef HIT_DEBOUNCE_EN
  task automatic test_debounce();
    i_rst = 1'b1; @(posedge i_clk); #1; i_rst = 1'b0;
    step(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) set_box(80, 100, 200, 220); else set_box(80, 100, 90, 110);
      q.push_back(k < 3 ? mk(1,0,0,0,0,0) : mk(0,0,1,0,0,0)); nq.push_back($sformatf("debounce_%0d", k));
      step(1'b1, 1'b0);
      e = q.pop_front(); n = nq.pop_front(); nchk++;
      if (outs() !== e) begin nerr++; $display("FAIL %s: got %h want %h", n, outs(), e); end
    end
  endtask
`endif

  initial begin
    set_box(0, 0, 0, 0);
    test_reset();
    test_start();
    test_scoring();
    test_reset_mid();
    test_touch();
    test_hit_over();
    test_restart();
    test_simultaneous();
`ifdef HIT_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
